// File: rtl/rt_msg_ctrl.sv
// MKIO remote-terminal message controller: decodes command words, moves data words
// between the bus and the dev2/dev4 subaddress RAMs, and times the status reply.
module rt_msg_ctrl #(
  parameter logic [4:0]  RT_ADDR     = 5'd1,
  parameter logic [4:0]  RX_SUBADDR  = 5'd2,
  parameter logic [4:0]  TX_SUBADDR  = 5'd4,
  parameter int unsigned CLK_PER_US  = 32,
  parameter int unsigned RESP_DLY_US = 5,
  parameter int unsigned WORD_TMO_US = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic        rx_csw,
  input  logic [15:0] rx_data,
  input  logic        rx_err,
  output logic        mem2_we,
  output logic [4:0]  mem2_addr,
  output logic [15:0] mem2_wdata,
  output logic        busy_dev2,
  output logic [4:0]  mem4_addr,
  input  logic [15:0] mem4_rdata,
  output logic        busy_dev4,
  output logic        tx_start,
  output logic        tx_csw,
  output logic [15:0] tx_data,
  input  logic        tx_busy
);

  // tmr holds the number of cycles elapsed since the cycle of the last accepted word
  localparam logic [15:0] RESP_LAST = 16'(RESP_DLY_US * CLK_PER_US - 1);
  localparam logic [15:0] WORD_TMO  = 16'(WORD_TMO_US * CLK_PER_US);

  typedef enum logic [2:0] {
    IDLE, RX_DATA, RESP_WAIT, TX_STATUS, TX_FETCH, TX_DATA, DONE
  } state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt, n_words;
  logic [15:0] tmr, tx_word;
  logic        tr_msg, sa_ok, msg_err, fetch_ph, start_d;

  logic        cmd_hit, cmd_tr, cmd_sa_ok;
  logic [4:0]  cmd_sa, cmd_wc;
  logic        accept_cmd, data_good, abort_rx;

  assign cmd_tr    = rx_data[10];
  assign cmd_sa    = rx_data[9:5];
  assign cmd_wc    = rx_data[4:0];
  assign cmd_sa_ok = cmd_tr ? (cmd_sa == TX_SUBADDR) : (cmd_sa == RX_SUBADDR);
  assign cmd_hit   = rx_valid && rx_csw && !rx_err &&
                     (rx_data[15:11] == RT_ADDR) && (rx_data[15:11] != 5'h1F);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept_cmd = 1'b0;
    data_good  = 1'b0;
    abort_rx   = 1'b0;
    case (state)
      IDLE: accept_cmd = cmd_hit;
      RX_DATA: begin
        if (rx_valid) begin
          if (rx_csw || rx_err) begin
            // a command word both aborts this message and may start the next one
            abort_rx   = 1'b1;
            state_nxt  = IDLE;
            accept_cmd = cmd_hit;
          end else begin
            data_good = 1'b1;
            if (cnt + 6'd1 == n_words) state_nxt = RESP_WAIT;
          end
        end else if (tmr >= WORD_TMO) begin
          abort_rx  = 1'b1;
          state_nxt = IDLE;
        end
      end
      RESP_WAIT: if (tmr == RESP_LAST) state_nxt = TX_STATUS;
      TX_STATUS: if (tx_start) state_nxt = (tr_msg && sa_ok) ? TX_FETCH : DONE;
      TX_FETCH:  if (fetch_ph) state_nxt = TX_DATA;
      TX_DATA:   if (tx_start) state_nxt = (cnt + 6'd1 < n_words) ? TX_FETCH : DONE;
      DONE:      if (!start_d && !tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (accept_cmd) state_nxt = cmd_tr ? RESP_WAIT : RX_DATA;
  end

  // start_d masks the cycle before the encoder raises tx_busy
  always_comb begin
    tx_start  = 1'b0;
    tx_csw    = 1'b0;
    tx_data   = '0;
    mem4_addr = '0;
    case (state)
      TX_STATUS: begin
        tx_start = !tx_busy && !start_d;
        tx_csw   = 1'b1;
        tx_data  = {RT_ADDR, msg_err, 10'b0};
      end
      TX_FETCH: mem4_addr = cnt[4:0];
      TX_DATA: begin
        tx_start = !tx_busy && !start_d;
        tx_data  = tx_word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      n_words    <= '0;
      tmr        <= '0;
      tx_word    <= '0;
      tr_msg     <= 1'b0;
      sa_ok      <= 1'b0;
      msg_err    <= 1'b0;
      fetch_ph   <= 1'b0;
      start_d    <= 1'b0;
      mem2_we    <= 1'b0;
      mem2_addr  <= '0;
      mem2_wdata <= '0;
      busy_dev2  <= 1'b0;
      busy_dev4  <= 1'b0;
    end else begin
      mem2_we  <= data_good && sa_ok;
      start_d  <= tx_start;
      fetch_ph <= (state == TX_FETCH) && !fetch_ph;
      if (data_good) begin
        mem2_addr  <= cnt[4:0];
        mem2_wdata <= rx_data;
      end
      if (state == TX_FETCH && fetch_ph) tx_word <= mem4_rdata;

      if (accept_cmd) begin
        tr_msg  <= cmd_tr;
        sa_ok   <= cmd_sa_ok;
        n_words <= (cmd_wc == '0) ? 6'd32 : {1'b0, cmd_wc};
        cnt     <= '0;
        tmr     <= 16'd1;
      end else begin
        if (data_good || (state == TX_DATA && tx_start)) cnt <= cnt + 6'd1;
        else if (state == TX_STATUS && tx_start)         cnt <= '0;
        if (data_good)                                   tmr <= 16'd1;
        else if (state == RX_DATA || state == RESP_WAIT) tmr <= tmr + 16'd1;
      end

      if (state == TX_STATUS && tx_start)                 msg_err <= 1'b0;
      else if (abort_rx || (accept_cmd && !cmd_sa_ok))    msg_err <= 1'b1;

      if (accept_cmd && !cmd_tr && cmd_sa == RX_SUBADDR)  busy_dev2 <= 1'b1;
      else if (abort_rx || (state == RESP_WAIT && state_nxt == TX_STATUS))
                                                          busy_dev2 <= 1'b0;

      if (accept_cmd && cmd_tr && cmd_sa == TX_SUBADDR)   busy_dev4 <= 1'b1;
      else if (state == DONE && state_nxt == IDLE)        busy_dev4 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rt_msg_ctrl.sv
// Self-checking bench for rt_msg_ctrl: message-level reference model with a
// behavioural encoder and dev4 RAM.
module tb_rt_msg_ctrl;

  localparam logic [4:0] RT   = 5'd1;
  localparam int         RESP = 160;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0, rx_csw = 1'b0, rx_err = 1'b0;
  logic [15:0] rx_data = '0;
  logic        mem2_we, busy_dev2, busy_dev4, tx_start, tx_csw;
  logic [4:0]  mem2_addr, mem4_addr;
  logic [15:0] mem2_wdata, tx_data;
  logic [15:0] mem4_rdata = '0;
  logic        tx_busy = 1'b0;

  rt_msg_ctrl #(
    .RT_ADDR(5'd1), .RX_SUBADDR(5'd2), .TX_SUBADDR(5'd4),
    .CLK_PER_US(32), .RESP_DLY_US(5), .WORD_TMO_US(24)
  ) dut (
    .clk(clk), .reset(reset),
    .rx_valid(rx_valid), .rx_csw(rx_csw), .rx_data(rx_data), .rx_err(rx_err),
    .mem2_we(mem2_we), .mem2_addr(mem2_addr), .mem2_wdata(mem2_wdata), .busy_dev2(busy_dev2),
    .mem4_addr(mem4_addr), .mem4_rdata(mem4_rdata), .busy_dev4(busy_dev4),
    .tx_start(tx_start), .tx_csw(tx_csw), .tx_data(tx_data), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  int viol = 0;
  int b2_fall = -1, b4_fall = -1;
  bit prev_start = 1'b0, b2_prev = 1'b0, b4_prev = 1'b0;
  bit m_me = 1'b0;

  logic [15:0] dev4 [32];
  logic [20:0] wr_q[$], exp_wr[$];
  logic [16:0] tx_q[$], exp_tx[$];
  int          tx_t[$], exp_t[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    mem4_rdata <= dev4[mem4_addr];
  end

  // encoder: busy from the cycle after tx_start for a random number of cycles
  initial forever begin
    @(negedge clk);
    if (tx_start && !reset) begin
      @(posedge clk);
      #1 tx_busy = 1'b1;
      repeat ($urandom_range(20, 50)) @(posedge clk);
      #1 tx_busy = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (mem2_we) wr_q.push_back({mem2_addr, mem2_wdata});
      if (tx_start) begin
        tx_q.push_back({tx_csw, tx_data});
        tx_t.push_back(cyc);
        if (tx_busy || prev_start) viol++;
      end
    end
    if (b2_prev && !busy_dev2) b2_fall = cyc;
    if (b4_prev && !busy_dev4) b4_fall = cyc;
    prev_start = tx_start;
    b2_prev    = busy_dev2;
    b4_prev    = busy_dev4;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] cmdw(input logic [4:0] a, input logic tr,
                                       input logic [4:0] sa, input logic [4:0] wc);
    return {a, tr, sa, wc};
  endfunction

  task automatic send(input logic csw, input logic [15:0] d, input logic err,
                      input int unsigned gap, output int t);
    repeat (gap) @(posedge clk);
    @(posedge clk);
    #1;
    rx_valid = 1'b1; rx_csw = csw; rx_data = d; rx_err = err;
    t = cyc;
    @(posedge clk);
    #1;
    rx_valid = 1'b0; rx_csw = 1'b0; rx_data = '0; rx_err = 1'b0;
  endtask

  task automatic exp_status(input int t_last);
    exp_tx.push_back({1'b1, RT, m_me, 10'b0});
    exp_t.push_back(t_last + RESP);
    m_me = 1'b0;
  endtask

  task automatic rx_full(input logic [4:0] sa, input logic [4:0] wc, input int unsigned gmax);
    int t;
    int unsigned n;
    logic [15:0] d;
    n = (wc == 5'd0) ? 32 : int'(wc);
    send(1'b1, cmdw(RT, 1'b0, sa, wc), 1'b0, 3, t);
    if (sa != 5'd2) m_me = 1'b1;
    for (int unsigned i = 0; i < n; i++) begin
      d = 16'($urandom);
      send(1'b0, d, 1'b0, $urandom_range(4, gmax), t);
      if (sa == 5'd2) exp_wr.push_back({5'(i), d});
    end
    exp_status(t);
  endtask

  task automatic tx_full(input logic [4:0] sa, input logic [4:0] wc);
    int t;
    int unsigned n;
    n = (wc == 5'd0) ? 32 : int'(wc);
    send(1'b1, cmdw(RT, 1'b1, sa, wc), 1'b0, 3, t);
    @(negedge clk);
    chk($sformatf("tx_sa%0d_busy4_on", sa), 64'(busy_dev4), 64'(sa == 5'd4));
    if (sa != 5'd4) m_me = 1'b1;
    exp_status(t);
    if (sa == 5'd4)
      for (int unsigned i = 0; i < n; i++) begin
        exp_tx.push_back({1'b0, dev4[5'(i)]});
        exp_t.push_back(-1);
      end
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (n < 4000 && !(n >= 200 && tx_q.size() >= exp_tx.size() &&
                             !tx_busy && !busy_dev4 && !busy_dev2));
    chk({tag, "_settle_tmo"}, 64'(n >= 4000), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_q();
    wr_q.delete(); exp_wr.delete();
    tx_q.delete(); tx_t.delete(); exp_tx.delete(); exp_t.delete();
  endtask

  task automatic check_msg(input string tag);
    chk({tag, "_nwr"}, 64'(wr_q.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), 64'(wr_q[i]), 64'(exp_wr[i]));
    chk({tag, "_ntx"}, 64'(tx_q.size()), 64'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++) begin
      chk($sformatf("%s_tx%0d", tag, i), 64'(tx_q[i]), 64'(exp_tx[i]));
      if (exp_t[i] >= 0) chk($sformatf("%s_txt%0d", tag, i), 64'(tx_t[i]), 64'(exp_t[i]));
    end
    clear_q();
  endtask

  initial begin
    int t, last;
    int unsigned n;
    logic [15:0] d;
    for (int i = 0; i < 32; i++) dev4[i] = 16'($urandom);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 64'({mem2_we, mem2_addr, mem2_wdata, busy_dev2, mem4_addr,
                           busy_dev4, tx_start, tx_csw, tx_data}), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);

    // test 1: receive 7 words to the RX subaddress
    send(1'b1, cmdw(RT, 1'b0, 5'd2, 5'd7), 1'b0, 2, t);
    @(negedge clk);
    chk("t1_busy2_on", 64'(busy_dev2), 64'd1);
    for (int unsigned i = 0; i < 7; i++) begin
      d = 16'($urandom);
      send(1'b0, d, 1'b0, $urandom_range(8, 60), t);
      exp_wr.push_back({5'(i), d});
    end
    chk("t1_busy2_held", 64'(busy_dev2), 64'd1);
    exp_status(t);
    wait_idle("t1");
    chk("t1_busy2_fall", 64'(b2_fall), 64'(t + RESP));
    check_msg("t1");
    for (int k = 0; k < 3; k++) begin
      rx_full(5'd2, 5'($urandom_range(1, 8)), 40);
      wait_idle("t1r");
      check_msg($sformatf("t1r%0d", k));
    end

    // test 2: transmit from dev4
    tx_full(5'd4, 5'd5);
    wait_idle("t2");
    last = (tx_t.size() > 0) ? tx_t[tx_t.size() - 1] : 32'h3FFF_FFFF;
    chk("t2_busy4_after_last", 64'(b4_fall > last), 64'd1);
    check_msg("t2");
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 32; i++) dev4[i] = 16'($urandom);
      tx_full(5'd4, 5'($urandom_range(1, 8)));
      wait_idle("t2r");
      check_msg($sformatf("t2r%0d", k));
    end

    // test 3: data word error aborts, ME reported on the next status only
    send(1'b1, cmdw(RT, 1'b0, 5'd2, 5'd3), 1'b0, 3, t);
    d = 16'($urandom);
    send(1'b0, d, 1'b0, 20, t);
    exp_wr.push_back({5'd0, d});
    send(1'b0, 16'($urandom), 1'b1, 20, t);
    m_me = 1'b1;
    @(negedge clk);
    chk("t3_busy2_abort", 64'(busy_dev2), 64'd0);
    wait_idle("t3");
    check_msg("t3");
    tx_full(5'd4, 5'd2);
    wait_idle("t3me");
    if (tx_q.size() > 0) chk("t3_status_me", 64'(tx_q[0]), 64'h1_0C00);
    check_msg("t3me");
    tx_full(5'd4, 5'd2);
    wait_idle("t3ok");
    if (tx_q.size() > 0) chk("t3_status_ok", 64'(tx_q[0]), 64'h1_0800);
    check_msg("t3ok");

    // test 4: inter-word timeout, then command word mid-message
    send(1'b1, cmdw(RT, 1'b0, 5'd2, 5'd4), 1'b0, 3, t);
    for (int unsigned i = 0; i < 2; i++) begin
      d = 16'($urandom);
      send(1'b0, d, 1'b0, 30, t);
      exp_wr.push_back({5'(i), d});
    end
    repeat (800) @(negedge clk);
    chk("t4_busy2_tmo", 64'(busy_dev2), 64'd0);
    m_me = 1'b1;
    wait_idle("t4a");
    check_msg("t4a");
    send(1'b1, cmdw(RT, 1'b0, 5'd2, 5'd4), 1'b0, 3, t);
    for (int unsigned i = 0; i < 2; i++) begin
      d = 16'($urandom);
      send(1'b0, d, 1'b0, 30, t);
      exp_wr.push_back({5'(i), d});
    end
    send(1'b1, cmdw(RT, 1'b0, 5'd2, 5'd2), 1'b0, 30, t);
    m_me = 1'b1;
    @(negedge clk);
    chk("t4_busy2_new", 64'(busy_dev2), 64'd1);
    for (int unsigned i = 0; i < 2; i++) begin
      d = 16'($urandom);
      send(1'b0, d, 1'b0, 30, t);
      exp_wr.push_back({5'(i), d});
    end
    exp_status(t);
    wait_idle("t4b");
    check_msg("t4b");

    // test 5: foreign and broadcast addresses, WC=0, bad subaddresses
    send(1'b1, cmdw(5'd3, 1'b0, 5'd2, 5'd3), 1'b0, 3, t);
    for (int i = 0; i < 3; i++) send(1'b0, 16'($urandom), 1'b0, 20, t);
    send(1'b1, cmdw(5'd31, 1'b0, 5'd2, 5'd3), 1'b0, 20, t);
    for (int i = 0; i < 3; i++) send(1'b0, 16'($urandom), 1'b0, 20, t);
    send(1'b1, cmdw(5'd3, 1'b1, 5'd4, 5'd2), 1'b0, 20, t);
    wait_idle("t5a");
    check_msg("t5a");
    rx_full(5'd2, 5'd0, 12);
    wait_idle("t5b");
    check_msg("t5b");
    rx_full(5'd9, 5'd2, 20);
    wait_idle("t5c");
    check_msg("t5c");
    tx_full(5'd7, 5'd3);
    wait_idle("t5d");
    check_msg("t5d");

    // test 6: asynchronous reset in the middle of a transmit
    tx_full(5'd4, 5'd5);
    n = 0;
    while (n < 3000 && tx_q.size() < 3) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reach_txdata", 64'(n >= 3000), 64'd0);
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_outs", 64'({mem2_we, mem2_addr, mem2_wdata, busy_dev2, mem4_addr,
                              busy_dev4, tx_start, tx_csw, tx_data}), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    clear_q();
    m_me = 1'b0;
    n = 0;
    while (n < 200 && tx_busy) begin
      @(negedge clk);
      n++;
    end
    rx_full(5'd2, 5'd2, 20);
    wait_idle("t6");
    check_msg("t6");

    chk("tx_start_rules", 64'(viol), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
